// File: rtl/dpram_stream_reader.sv
// Sequential read initiator for one port of the dual-port RAM. It absorbs the 1-cycle
// read latency and streams words out of a small first-word-fall-through FIFO over valid/ready.
//
// state   | meaning
// S_IDLE  | waiting for start; a zero-length start only pulses done
// S_RUN   | issuing reads while FIFO credit is available
// S_DRAIN | all reads issued; waiting for the consumer to pop the last word
module dpram_stream_reader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_enable,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]      DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   pending;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        credit_used;

    // A word in flight already owns a FIFO slot, so overflow cannot happen on capture.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign issue       = (state == S_RUN) && (remaining != '0) && (credit_used < DEPTH_C);
    assign push        = inflight;
    assign pop         = out_valid && out_ready;

    assign mem_enable  = issue;
    assign mem_addr    = addr;
    assign mem_wren    = 1'b0;
    assign out_valid   = (fifo_count != '0);
    assign out_data    = fifo_mem[rd_ptr];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr       <= '0;
            remaining  <= '0;
            pending    <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (abort) begin
            // Flush everything, including a word whose read data arrives next cycle.
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            pending    <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;

            if (push) begin
                fifo_mem[wr_ptr] <= mem_q;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - ONE_W;
            end
            if (pop) begin
                pending <= pending - ONE_W;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state     <= S_RUN;
                            busy      <= 1'b1;
                            addr      <= start_addr;
                            remaining <= length;
                            pending   <= length;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue && (remaining == ONE_W)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && (pending == ONE_W)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: RAM model with 1-cycle read latency, a transfer-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_dpram_stream_reader;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_enable;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    dpram_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_enable (mem_enable),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk_sys = ~clk_sys;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) mem_q <= '0;
        else          mem_q <= mem_enable ? ram[mem_addr] : '0;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: words are tracked as issued / landed / popped counts.
    bit            m_busy, m_done, m_infl;
    logic [AW-1:0] m_addr;
    int            m_left, m_out, m_avail;
    logic [DW-1:0] m_q[$];
    int            cyc = 0;
    int            obs_out = 0;

    logic [DW-1:0] pop_data[$];
    int            pop_cyc[$];
    logic [AW-1:0] iss_addr[$];
    int            done_cyc[$];

    always @(negedge clk_sys) begin : compare
        bit exp_issue, exp_valid, pop, was_busy, nd;
        int nxt_avail;
        logic [AW-1:0] a;
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_infl = 0; m_addr = '0;
            m_left = 0; m_out = 0; m_avail = 0; obs_out = 0;
            m_q.delete();
        end else begin
            cyc++;
            exp_issue = m_busy && (m_left > 0) && (m_out < DEPTH);
            exp_valid = (m_avail > 0);
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("mem_wren", 64'(mem_wren), 64'd0);
            chk("mem_enable", 64'(mem_enable), 64'(exp_issue));
            if (exp_issue) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid) chk("out_data", 64'(out_data), 64'(m_q[0]));

            if (mem_enable) begin iss_addr.push_back(mem_addr); obs_out++; end
            if (out_valid && out_ready) begin
                pop_data.push_back(out_data); pop_cyc.push_back(cyc); obs_out--;
            end
            if (done) done_cyc.push_back(cyc);
            n_cmp++;
            a_no_overflow: assert (obs_out <= DEPTH) else begin
                n_err++;
                $display("FAIL no_overflow: %0d words outstanding, limit %0d", obs_out, DEPTH);
            end
            if (abort) obs_out = 0;

            pop      = exp_valid && out_ready;
            was_busy = m_busy;
            nd       = 0;
            if (abort) begin
                m_busy = 0; m_q.delete(); m_left = 0; m_out = 0; m_avail = 0; m_infl = 0;
            end else begin
                nxt_avail = m_avail + (m_infl ? 1 : 0) - (pop ? 1 : 0);
                m_avail   = nxt_avail;
                m_infl    = exp_issue;
                if (exp_issue) begin m_addr++; m_left--; m_out++; end
                if (pop) begin
                    void'(m_q.pop_front());
                    m_out--;
                    if (m_busy && m_q.size() == 0) begin m_busy = 0; nd = 1; end
                end
                if (!was_busy && start) begin
                    if (length == '0) nd = 1;
                    else begin
                        m_busy = 1; m_addr = start_addr; m_left = int'(length);
                        for (int i = 0; i < int'(length); i++) begin
                            a = start_addr + AW'(i);
                            m_q.push_back(ram[a]);
                        end
                    end
                end
            end
            m_done = nd;
        end
    end

    task automatic tick(); @(posedge clk_sys); #1; endtask
    task automatic smp();  @(negedge clk_sys); #1; endtask

    task automatic clear_logs();
        pop_data.delete(); pop_cyc.delete(); iss_addr.delete(); done_cyc.delete();
    endtask

    task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] l);
        tick(); start = 1'b1; start_addr = a; length = l;
        tick(); start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int max);
        int i;
        for (i = 0; i < max; i++) begin
            smp();
            if (done) break;
        end
        n_cmp++;
        if (i == max) begin
            n_err++;
            $display("FAIL %s_timeout: done not seen, expected within %0d cycles", nm, max);
        end
    endtask

    initial begin
        int base, errs;
        logic [AW-1:0] exp3 [4];
        logic [AW-1:0] a;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start_addr = '0; length = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            a = AW'(i);
            ram[i] = a[7:0] + a[15:8];
        end
        for (int i = 0; i < 8; i++) ram[16'h0100 + i] = DW'(i + 1);

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 0);       chk("rst_done", 64'(done), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0); chk("rst_mem_en", 64'(mem_enable), 0);
        chk("rst_out_valid", 64'(out_valid), 0); chk("rst_out_data", 64'(out_data), 0);
        reset_n = 1'b1;

        // Basic 8-word transfer, consumer always ready
        clear_logs(); out_ready = 1'b1;
        do_start(16'h0100, 17'd8);
        smp(); base = cyc;
        chk("t1_valid_k0", 64'(out_valid), 0); chk("t1_busy_k0", 64'(busy), 1);
        chk("t1_en_k0", 64'(mem_enable), 1);
        smp(); chk("t1_valid_k1", 64'(out_valid), 0);
        smp(); chk("t1_valid_k2", 64'(out_valid), 1); chk("t1_data_k2", 64'(out_data), 64'h01);
        wait_done("t1", 40);
        chk("t1_busy_at_done", 64'(busy), 0);
        chk("t1_npop", 64'(pop_data.size()), 8);
        for (int i = 0; i < 8 && i < pop_data.size(); i++) begin
            chk("t1_data", 64'(pop_data[i]), 64'(i + 1));
            chk("t1_pop_cycle", 64'(pop_cyc[i] - base), 64'(2 + i));
        end
        if (done_cyc.size() > 0) chk("t1_done_cycle", 64'(done_cyc[0] - base), 10);
        smp(); chk("t1_done_once", 64'(done_cyc.size()), 1);

        // Stalled consumer: only FIFO_DEPTH reads may be outstanding
        clear_logs(); out_ready = 1'b0;
        do_start(16'h0100, 17'd8);
        for (int k = 0; k < 10; k++) begin
            smp();
            if (out_valid) chk("t2_head_hold", 64'(out_data), 64'h01);
        end
        chk("t2_reads_stalled", 64'(iss_addr.size()), DEPTH);
        tick(); out_ready = 1'b1;
        wait_done("t2", 40);
        chk("t2_npop", 64'(pop_data.size()), 8);
        for (int i = 0; i < 8 && i < pop_data.size(); i++)
            chk("t2_data", 64'(pop_data[i]), 64'(i + 1));

        // Address wrap
        clear_logs();
        do_start(16'hFFFE, 17'd4);
        wait_done("t3", 40);
        exp3 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        chk("t3_nreads", 64'(iss_addr.size()), 4);
        for (int i = 0; i < 4 && i < iss_addr.size(); i++)
            chk("t3_addr", 64'(iss_addr[i]), 64'(exp3[i]));
        chk("t3_npop", 64'(pop_data.size()), 4);
        if (pop_data.size() == 4) begin
            chk("t3_d0", 64'(pop_data[0]), 64'hFD); chk("t3_d1", 64'(pop_data[1]), 64'hFE);
            chk("t3_d2", 64'(pop_data[2]), 64'h00); chk("t3_d3", 64'(pop_data[3]), 64'h01);
        end

        // Zero-length transfer
        clear_logs();
        do_start(16'h1234, 17'd0);
        smp();
        chk("t4_done", 64'(done), 1); chk("t4_busy", 64'(busy), 0);
        repeat (4) begin
            smp();
            chk("t4_done_after", 64'(done), 0); chk("t4_busy_after", 64'(busy), 0);
        end
        chk("t4_no_reads", 64'(iss_addr.size()), 0);

        // Abort after three pops with a read in flight
        clear_logs(); out_ready = 1'b1;
        do_start(16'h0100, 17'd8);
        for (int k = 0; k < 30; k++) begin
            smp();
            if (pop_data.size() >= 3) break;
        end
        chk("t5_pops_before_abort", 64'(pop_data.size()), 3);
        tick(); abort = 1'b1; out_ready = 1'b0;
        tick(); abort = 1'b0;
        smp();
        chk("t5_busy", 64'(busy), 0); chk("t5_valid", 64'(out_valid), 0);
        chk("t5_done", 64'(done), 0); chk("t5_en", 64'(mem_enable), 0);
        repeat (3) begin
            smp(); chk("t5_valid_after", 64'(out_valid), 0);
        end
        chk("t5_no_done", 64'(done_cyc.size()), 0);
        clear_logs(); out_ready = 1'b1;
        do_start(16'h0100, 17'd2);
        wait_done("t5b", 20);
        chk("t5b_npop", 64'(pop_data.size()), 2);
        if (pop_data.size() == 2) begin
            chk("t5b_d0", 64'(pop_data[0]), 64'h01); chk("t5b_d1", 64'(pop_data[1]), 64'h02);
        end

        // Abort wins over a same-cycle start
        clear_logs();
        tick(); abort = 1'b1; start = 1'b1; start_addr = 16'h0100; length = 17'd3;
        tick(); abort = 1'b0; start = 1'b0;
        repeat (3) begin
            smp(); chk("t5c_busy", 64'(busy), 0); chk("t5c_en", 64'(mem_enable), 0);
        end
        chk("t5c_no_done", 64'(done_cyc.size()), 0);

        // Asynchronous reset mid-transfer
        clear_logs();
        do_start(16'h0100, 17'd8);
        smp(); smp(); smp();
        #1 reset_n = 1'b0;
        #1;
        chk("t7_busy", 64'(busy), 0); chk("t7_valid", 64'(out_valid), 0);
        chk("t7_en", 64'(mem_enable), 0); chk("t7_addr", 64'(mem_addr), 0);
        chk("t7_data", 64'(out_data), 0);
        repeat (2) tick();
        reset_n = 1'b1;

        // 256 words with a random consumer and a stray start while busy
        clear_logs();
        do_start(16'h0300, 17'd256);
        begin : t6_loop
            int i;
            for (i = 0; i < 3000; i++) begin
                tick();
                out_ready = 1'($urandom_range(0, 1));
                start = (i == 20);
                if (i == 20) begin start_addr = 16'h0100; length = 17'd5; end
                smp();
                if (done) break;
            end
            start = 1'b0;
            n_cmp++;
            if (i == 3000) begin
                n_err++;
                $display("FAIL t6_timeout: done not seen, expected within 3000 cycles");
            end
        end
        chk("t6_npop", 64'(pop_data.size()), 256);
        errs = 0;
        for (int i = 0; i < pop_data.size() && i < 256; i++) begin
            a = 16'h0300 + AW'(i);
            if (pop_data[i] !== ram[a]) errs++;
        end
        chk("t6_data_errors", 64'(errs), 0);
        out_ready = 1'b1;
        repeat (3) smp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
